// File: rtl/regfile_arbiter_if.sv
// Requester-side and register-file-side signals of the shared two-port register file.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface regfile_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [DW-1:0]      rdata2;
  logic [AW-1:0]      address1;
  logic [AW-1:0]      address2;
  logic [DW-1:0]      in_data1;
  logic [DW-1:0]      in_data2;
  logic               w_en;
  logic [DW-1:0]      out_data1;
  logic [DW-1:0]      out_data2;

  modport slave (
    input  req, we, addr, wdata, out_data1, out_data2,
    output gnt, rvalid, rdata, rdata2, address1, address2, in_data1, in_data2, w_en
  );

  modport master (
    output req, we, addr, wdata, out_data1, out_data2,
    input  gnt, rvalid, rdata, rdata2, address1, address2, in_data1, in_data2, w_en
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing a two-port register file (one shared write enable)
// among NREQ requesters: up to two reads or two writes per cycle, never mixed.
module regfile_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 8
) (
  input logic              clk,
  input logic              rst,
  regfile_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_rr_ptr;
  logic [NREQ-1:0] r_rvalid;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_rdata2;

  logic [AW-1:0]   w_addr [NREQ];
  logic [DW-1:0]   w_wdat [NREQ];
  logic            w_has_p;
  logic            w_has_s;
  logic [PW-1:0]   w_pidx;
  logic [PW-1:0]   w_sidx;
  logic [PW-1:0]   w_j;
  logic            w_wr;
  logic [NREQ-1:0] w_gnt;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_addr[i] = bus.addr[i*AW +: AW];
      w_wdat[i] = bus.wdata[i*DW +: DW];
    end
  end

  // Scan from the pointer: first requester is primary; the next eligible one of the
  // same type is secondary, skipping writes that collide with the primary's address.
  always_comb begin
    w_has_p = 1'b0;
    w_has_s = 1'b0;
    w_pidx  = '0;
    w_sidx  = '0;
    w_j     = '0;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        w_j = rr_idx(r_rr_ptr, k);
        if (!w_has_p) begin
          if (bus.req[w_j]) begin
            w_has_p = 1'b1;
            w_pidx  = w_j;
          end
        end else if (!w_has_s && bus.req[w_j] && (bus.we[w_j] == bus.we[w_pidx]) &&
                     !(bus.we[w_j] && (w_addr[w_j] == w_addr[w_pidx]))) begin
          w_has_s = 1'b1;
          w_sidx  = w_j;
        end
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (w_has_p) w_gnt[w_pidx] = 1'b1;
    if (w_has_s) w_gnt[w_sidx] = 1'b1;
  end

  assign w_wr = w_has_p & bus.we[w_pidx];

  assign bus.gnt      = w_gnt;
  assign bus.w_en     = w_wr;
  assign bus.address1 = w_has_p ? w_addr[w_pidx] : '0;
  assign bus.in_data1 = w_has_p ? w_wdat[w_pidx] : '0;
  assign bus.address2 = w_has_s ? w_addr[w_sidx] : '0;
  assign bus.in_data2 = w_has_s ? w_wdat[w_sidx] : '0;
  assign bus.rvalid   = r_rvalid;
  assign bus.rdata    = r_rdata;
  assign bus.rdata2   = r_rdata2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_rdata2 <= '0;
    end else begin
      if (w_has_p)
        r_rr_ptr <= (int'(w_pidx) == NREQ-1) ? '0 : w_pidx + 1'b1;
      r_rvalid <= (w_has_p && !w_wr) ? w_gnt : '0;
      if (w_has_p && !w_wr) begin
        r_rdata <= bus.out_data1;
        if (w_has_s) r_rdata2 <= bus.out_data2;
      end
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench: a request-list model predicts grants and read returns; a monitor
// pops expected read returns when the arbiter presents them.
module tb_regfile_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  regfile_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Register file seen by the arbiter; port 1 wins if both ports hit one address.
  logic [DW-1:0] mem [2**AW];
  assign bus.out_data1 = mem[bus.address1];
  assign bus.out_data2 = mem[bus.address2];
  always @(posedge clk) if (bus.w_en) begin
    mem[bus.address2] <= bus.in_data2;
    mem[bus.address1] <= bus.in_data1;
  end

  typedef struct {
    int              due;
    logic [NREQ-1:0] vld;
    logic [DW-1:0]   d1;
    logic [DW-1:0]   d2;
    bit              two;
  } exp_t;

  exp_t            q[$];
  logic [DW-1:0]   ref_mem [2**AW];
  int              ptr;
  bit [NREQ-1:0]   m_gnt;
  int              passes = 0;
  int              fails = 0;
  int              cyc = 0;
  int              waitc [NREQ];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: list requesters in pointer order, pick primary and same-type partner.
  int            order[$];
  int            p_i, s_i, idx;
  logic [NREQ-1:0] e_gnt;
  logic [AW-1:0] e_a1, e_a2;
  logic [DW-1:0] e_d1, e_d2;
  exp_t          e_new;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_wen", bus.w_en, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_rdata2", bus.rdata2, 0);
      ptr = 0;
      q.delete();
      m_gnt = '0;
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    end else begin
      order.delete();
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr + k) % NREQ;
        if (bus.req[idx]) order.push_back(idx);
      end
      p_i = -1; s_i = -1;
      if (order.size() > 0) begin
        p_i = order[0];
        for (int i = 1; i < order.size(); i++)
          if (s_i < 0 && bus.we[order[i]] == bus.we[p_i] &&
              !(bus.we[p_i] && bus.addr[order[i]*AW +: AW] == bus.addr[p_i*AW +: AW]))
            s_i = order[i];
      end
      e_gnt = '0; e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0;
      if (p_i >= 0) begin
        e_gnt[p_i] = 1'b1;
        e_a1 = bus.addr[p_i*AW +: AW];
        e_d1 = bus.wdata[p_i*DW +: DW];
      end
      if (s_i >= 0) begin
        e_gnt[s_i] = 1'b1;
        e_a2 = bus.addr[s_i*AW +: AW];
        e_d2 = bus.wdata[s_i*DW +: DW];
      end
      chk("gnt", bus.gnt, e_gnt);
      chk("w_en", bus.w_en, (p_i >= 0 && bus.we[p_i]) ? 1 : 0);
      chk("address1", bus.address1, e_a1);
      chk("in_data1", bus.in_data1, e_d1);
      chk("address2", bus.address2, e_a2);
      chk("in_data2", bus.in_data2, e_d2);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && !bus.gnt[i]) waitc[i]++;
        else waitc[i] = 0;
      end
      for (int i = 0; i < NREQ; i++)
        if (waitc[i] != 0) chk("starvation_bound", (waitc[i] < NREQ) ? 1 : 0, 1);
      if (p_i >= 0) begin
        if (bus.we[p_i]) begin
          ref_mem[e_a2] = e_d2;
          ref_mem[e_a1] = e_d1;
        end else begin
          e_new.due = cyc + 1;
          e_new.vld = e_gnt;
          e_new.d1  = ref_mem[e_a1];
          e_new.d2  = (s_i >= 0) ? ref_mem[e_a2] : '0;
          e_new.two = (s_i >= 0);
          q.push_back(e_new);
        end
        ptr = (p_i + 1) % NREQ;
      end
      m_gnt = e_gnt;
    end
  end

  // Monitor: read returns are due exactly one cycle after the grant.
  exp_t e_pop;
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e_pop = q.pop_front();
        chk("rvalid", bus.rvalid, e_pop.vld);
        chk("rdata", bus.rdata, e_pop.d1);
        if (e_pop.two) chk("rdata2", bus.rdata2, e_pop.d2);
      end else begin
        chk("rvalid_idle", bus.rvalid, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic set_req(input int i, input bit r, input bit w, input int a, input int d);
    bus.req[i] = r;
    bus.we[i] = w;
    bus.addr[i*AW +: AW] = AW'(a);
    bus.wdata[i*DW +: DW] = DW'(d);
  endtask

  task automatic do_reset();
    bus.req = '0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
  endtask

  logic [DW-1:0] v;
  logic [NREQ-1:0] rot_tbl [6];

  initial begin
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 2**AW; i++) begin
      v = DW'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    // Reset holds grants off even with every requester active
    bus.req = '1;
    at_neg();
    chk("rst_gnt_allreq", bus.gnt, 0);
    step(); step();
    bus.req = '0;
    rst = 1'b0;

    // Single write
    set_req(0, 1, 1, 9, 45);
    at_neg();
    chk("w1_gnt", bus.gnt, 3'b001);
    chk("w1_wen", bus.w_en, 1);
    chk("w1_addr1", bus.address1, 9);
    chk("w1_data1", bus.in_data1, 45);
    step(); bus.req = '0;

    // Dual read
    do_reset();
    set_req(0, 1, 0, 9, 0); set_req(1, 1, 0, 13, 0);
    at_neg();
    chk("r2_gnt", bus.gnt, 3'b011);
    chk("r2_wen", bus.w_en, 0);
    step(); bus.req = '0;
    at_neg();
    chk("r2_rvalid", bus.rvalid, 3'b011);
    chk("r2_rdata", bus.rdata, 45);

    // Two writes to the same address serialize in pointer order
    do_reset();
    set_req(0, 1, 1, 13, 44); set_req(1, 1, 1, 13, 7);
    at_neg();
    chk("ww_gnt1", bus.gnt, 3'b001);
    step(); bus.req[0] = 1'b0;
    at_neg();
    chk("ww_gnt2", bus.gnt, 3'b010);
    chk("ww_mem1", mem[13], 44);
    step(); bus.req = '0;
    at_neg();
    chk("ww_mem2", mem[13], 7);

    // Mixed types: reads first, write deferred
    do_reset();
    set_req(0, 1, 0, 1, 0); set_req(1, 1, 1, 2, 99); set_req(2, 1, 0, 3, 0);
    at_neg();
    chk("mix_gnt1", bus.gnt, 3'b101);
    step(); bus.req = 3'b010;
    at_neg();
    chk("mix_gnt2", bus.gnt, 3'b010);
    chk("mix_wen2", bus.w_en, 1);
    step(); bus.req = '0;

    // Continuous reads rotate the primary
    do_reset();
    rot_tbl = '{3'b011, 3'b110, 3'b101, 3'b011, 3'b110, 3'b101};
    set_req(0, 1, 0, 4, 0); set_req(1, 1, 0, 5, 0); set_req(2, 1, 0, 6, 0);
    for (int i = 0; i < 6; i++) begin
      at_neg();
      chk("rot_gnt", bus.gnt, rot_tbl[i]);
      step();
    end
    bus.req = '0;

    // Asynchronous reset the cycle after a read grant
    do_reset();
    set_req(0, 1, 0, 9, 0);
    at_neg();
    chk("ar_gnt", bus.gnt, 3'b001);
    step();
    bus.req = '0;
    chk("ar_rvalid_pre", bus.rvalid, 3'b001);
    set_req(0, 1, 1, 2, 5); set_req(2, 1, 1, 3, 6);
    #2 rst = 1'b1;
    #1;
    chk("ar_rvalid", bus.rvalid, 0);
    chk("ar_wen", bus.w_en, 0);
    chk("ar_gnt_rst", bus.gnt, 0);
    step(); rst = 1'b0;
    bus.req = '0;
    set_req(0, 1, 0, 4, 0); set_req(2, 1, 0, 6, 0);
    at_neg();
    chk("ar_gnt_after", bus.gnt, 3'b101);
    step(); bus.req = '0;

    // Random traffic with hold-until-grant and occasional abandonment
    for (int n = 0; n < 600; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i] || !bus.req[i])
          set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 255));
        else if ($urandom_range(0, 9) == 0)
          bus.req[i] = 1'b0;
      end
    end
    step(); bus.req = '0;
    step(); step();
    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, meaning the number of requesters sharing the register file (fixed range 2..4).
REQ-002 The block SHALL have parameter AW, default 5, meaning the register-file address width.
REQ-003 The block SHALL have parameter DW, default 8, meaning the register-file data width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-005 req  input  NREQ  per-requester access request, held until granted.
REQ-006 we  input  NREQ  per-requester operation, 1 = write, 0 = read.
REQ-007 addr  input  NREQ*AW  per-requester register address, requester i at bits [i*AW +: AW].
REQ-008 wdata  input  NREQ*DW  per-requester write data, requester i at bits [i*DW +: DW].
REQ-009 gnt  output  NREQ  per-requester grant, combinational, one-hot or two-hot.
REQ-010 rvalid  output  NREQ  per-requester read-data-valid, registered.
REQ-011 rdata  output  DW  registered read data for the requester flagged by rvalid.
REQ-012 rdata2  output  DW  registered read data for the second read granted in the same cycle.
REQ-013 address1, address2  output  AW each  register-file port addresses.
REQ-014 in_data1, in_data2  output  DW each  register-file port write data.
REQ-015 w_en  output  1  register-file write enable, shared by both ports.
REQ-016 out_data1, out_data2  input  DW each  register-file combinational read data.

Function
REQ-017 The register file SHALL be treated as combinational: two ports, one shared w_en, so each cycle is either a read cycle (two reads max) or a write cycle (two writes max), never mixed.
REQ-018 The arbiter SHALL hold a round-robin pointer rr_ptr (0..NREQ-1) and scan requesters starting at rr_ptr.
REQ-019 The first requesting index found (primary) SHALL be granted and SHALL set the cycle type from its we bit.
REQ-020 Continuing the scan, the next requester of the same type (secondary) SHALL also be granted, except for a write whose addr equals the primary's addr.
REQ-021 Requesters of the opposite type, and a same-address write, SHALL NOT be granted that cycle and SHALL keep req asserted.
REQ-022 Primary SHALL drive port 1 (address1, in_data1); secondary SHALL drive port 2; an unused port SHALL drive address 0, data 0.
REQ-023 w_en SHALL be 1 only in a write cycle with at least one grant; with no requests, w_en = 0 and all port outputs = 0.
REQ-024 On each clock edge with any grant, rr_ptr SHALL become (primary index + 1) mod NREQ; with no grant it SHALL hold.
REQ-025 In a read cycle, out_data1/out_data2 SHALL be registered into rdata/rdata2 and rvalid SHALL assert for exactly one cycle on the granted read requesters, latency 1 clock after gnt.
REQ-026 rvalid, rdata and rdata2 SHALL hold their last values; rvalid SHALL return to 0 in cycles following a non-read cycle.
REQ-027 A requester deasserting req before gnt SHALL simply be dropped; there SHALL be no pending state.
REQ-028 Any requester SHALL be granted within NREQ cycles of continuous assertion (no starvation).

Reset
REQ-029 While rst = 1, rr_ptr = 0, rvalid = 0, rdata = 0 and rdata2 = 0; gnt and w_en SHALL be 0 regardless of req.
REQ-030 Reset asserted mid-operation SHALL abort any read return (rvalid cleared immediately); no write SHALL occur while rst = 1.

Verification
REQ-031 After reset, req = 3'b001, we = 1, addr0 = 9, wdata0 = 45 -> gnt = 001, w_en = 1, address1 = 9, in_data1 = 45.
REQ-032 req = 3'b011, both reads, addr0 = 9, addr1 = 13 -> gnt = 011, w_en = 0; the next cycle shows rvalid = 011, rdata = mem[9], rdata2 = mem[13].
REQ-033 req = 3'b011, both writes to address 13 with data 44 and 7, rr_ptr = 0 -> cycle 1: gnt = 001, mem[13] = 44; cycle 2: gnt = 010, mem[13] = 7.
REQ-034 req = 3'b111, we = 3'b010, rr_ptr = 0 -> cycle 1 grants reads 0 and 2 (gnt = 101); cycle 2 grants write 1 (gnt = 010).
REQ-035 All three requesters are held as continuous reads for 6 cycles -> each is primary exactly twice, and rr_ptr follows the sequence 0, 1 or 2 in round-robin order.
REQ-036 rst asserts asynchronously in the cycle after a read grant -> rvalid = 0 immediately, w_en = 0, and rr_ptr = 0 after release.
